// File: rtl/alu_issue_stage.sv
// Issue stage around the combinational alu: operand register in front,
// 2-entry result buffer behind, plus architectural flags and op counters.
module alu_issue_stage #(
  parameter int BUS_WIDTH   = 32,
  parameter int TAG_WIDTH   = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_opcode,
  input  logic [BUS_WIDTH-1:0]   in_num_0,
  input  logic [BUS_WIDTH-1:0]   in_num_1,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  input  logic                   in_set_flags,
  output logic [3:0]             alu_opcode,
  output logic [BUS_WIDTH-1:0]   alu_num_0,
  output logic [BUS_WIDTH-1:0]   alu_num_1,
  input  logic [BUS_WIDTH-1:0]   alu_num_out,
  input  logic                   alu_over,
  input  logic                   alu_zero,
  input  logic                   alu_greater,
  input  logic                   alu_equal,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BUS_WIDTH-1:0]   out_data,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic [3:0]             out_flags,
  output logic [3:0]             flags_q,
  output logic                   illegal_seen,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  localparam logic [3:0] OP_NUL = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b1000;

  logic                   r_s1_valid;
  logic [3:0]             r_opcode;
  logic [BUS_WIDTH-1:0]   r_num_0;
  logic [BUS_WIDTH-1:0]   r_num_1;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic                   r_set_flags;

  logic [BUS_WIDTH-1:0]   r_data  [2];
  logic [TAG_WIDTH-1:0]   r_btag  [2];
  logic [3:0]             r_bflag [2];
  logic                   r_wptr;
  logic                   r_rptr;
  logic [1:0]             r_count;

  logic [3:0]             r_flags_q;
  logic                   r_illegal;
  logic [COUNT_WIDTH-1:0] r_retired;

  logic                   w_legal;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_accept;
  logic [3:0]             w_alu_flags;

  always_comb begin
    w_legal = 1'b0;
    unique case (in_opcode)
      OP_NUL, OP_ADD, OP_SUB,
      OP_XOR, OP_AND, OP_OR: w_legal = 1'b1;
      default:               w_legal = 1'b0;
    endcase
  end

  assign w_alu_flags = {alu_over, alu_zero, alu_greater, alu_equal};
  assign out_valid   = (r_count != 2'd0);
  assign w_pop       = out_valid && out_ready;
  // S1 may drain into a full buffer only when the head leaves this cycle
  assign w_push      = r_s1_valid && ((r_count != 2'd2) || w_pop);
  assign in_ready    = !r_s1_valid || w_push;
  assign w_accept    = in_valid && in_ready;

  assign alu_opcode    = r_opcode;
  assign alu_num_0     = r_num_0;
  assign alu_num_1     = r_num_1;
  assign out_data      = r_data[r_rptr];
  assign out_tag       = r_btag[r_rptr];
  assign out_flags     = r_bflag[r_rptr];
  assign flags_q       = r_flags_q;
  assign illegal_seen  = r_illegal;
  assign retired_count = r_retired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_opcode    <= OP_NUL;
      r_num_0     <= '0;
      r_num_1     <= '0;
      r_tag       <= '0;
      r_set_flags <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid  <= 1'b1;
        r_opcode    <= w_legal ? in_opcode : OP_NUL;
        r_num_0     <= in_num_0;
        r_num_1     <= in_num_1;
        r_tag       <= in_tag;
        r_set_flags <= in_set_flags;
        if (!w_legal)
          r_illegal <= 1'b1;
      end else if (w_push) begin
        r_s1_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i]  <= '0;
        r_btag[i]  <= '0;
        r_bflag[i] <= '0;
      end
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
      r_flags_q <= 4'd0;
      r_retired <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr]  <= alu_num_out;
        r_btag[r_wptr]  <= r_tag;
        r_bflag[r_wptr] <= w_alu_flags;
        r_wptr          <= ~r_wptr;
        r_retired       <= r_retired + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        if (r_set_flags)
          r_flags_q <= w_alu_flags;
      end
      if (w_pop)
        r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, backpressure and reset
// sequences, and a randomized run against an in-order result queue model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [31:0] in_num_0;
  logic [31:0] in_num_1;
  logic [3:0]  in_tag;
  logic        in_set_flags;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_num_0;
  logic [31:0] alu_num_1;
  logic [31:0] alu_num_out;
  logic        alu_over, alu_zero, alu_greater, alu_equal;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;
  logic [3:0]  flags_q;
  logic        illegal_seen;
  logic [15:0] retired_count;

  always #5 clk = ~clk;

  alu_issue_stage #(
    .BUS_WIDTH(32), .TAG_WIDTH(4), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_num_0(in_num_0), .in_num_1(in_num_1),
    .in_tag(in_tag), .in_set_flags(in_set_flags),
    .alu_opcode(alu_opcode), .alu_num_0(alu_num_0), .alu_num_1(alu_num_1),
    .alu_num_out(alu_num_out),
    .alu_over(alu_over), .alu_zero(alu_zero),
    .alu_greater(alu_greater), .alu_equal(alu_equal),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_flags(out_flags),
    .flags_q(flags_q), .illegal_seen(illegal_seen),
    .retired_count(retired_count)
  );

  // Behavioural alu: {result, over, zero, greater, equal}
  function automatic logic [35:0] alu_f(logic [3:0] op, logic [31:0] a,
                                        logic [31:0] b);
    logic [32:0] s;
    logic [31:0] res;
    logic        ov;
    ov = 1'b0;
    case (op)
      4'd1:    begin s = {1'b0, a} + {1'b0, b}; res = s[31:0]; ov = s[32]; end
      4'd2:    begin res = a - b; ov = (a < b); end
      4'd3:    res = a ^ b;
      4'd4:    res = a & b;
      4'd8:    res = a | b;
      default: res = 32'd0;
    endcase
    return {res, ov, (res == 32'd0), (a > b), (a == b)};
  endfunction

  function automatic bit legal(logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8};
  endfunction

  always_comb
    {alu_num_out, alu_over, alu_zero, alu_greater, alu_equal} =
      alu_f(alu_opcode, alu_num_0, alu_num_1);

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic [3:0]  f;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    bit          sf;
    logic [31:0] d;
    logic [3:0]  f;
  } vec_t;

  res_t        expq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acc   = 0;
  int          n_pops  = 0;
  logic [3:0]  exp_fq  = 4'd0;
  bit          exp_ill = 1'b0;
  bit          last_acc;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, check head against model, advance.
  task automatic cyc(bit v, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                     logic [3:0] tg, bit sf, bit rdy);
    res_t        r;
    logic [35:0] x;
    bit          pop;
    in_valid     = v;
    in_opcode    = op;
    in_num_0     = a;
    in_num_1     = b;
    in_tag       = tg;
    in_set_flags = sf;
    out_ready    = rdy;
    #1;
    last_acc = in_valid && in_ready;
    pop      = out_valid && out_ready;
    if (out_valid) begin
      if (expq.size() == 0) begin
        chk("out_valid_vs_model", out_valid, 0);
      end else begin
        chk("head_data", out_data, expq[0].d);
        chk("head_tag", out_tag, expq[0].t);
        chk("head_flags", out_flags, expq[0].f);
        if (pop) begin
          void'(expq.pop_front());
          n_pops++;
        end
      end
    end
    if (last_acc) begin
      x   = alu_f(legal(op) ? op : 4'd0, a, b);
      r.d = x[35:4];
      r.t = tg;
      r.f = x[3:0];
      expq.push_back(r);
      n_acc++;
      if (sf) exp_fq = x[3:0];
      if (!legal(op)) exp_ill = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(bit rdy);
    cyc(0, 4'd0, 32'd0, 32'd0, 4'd0, 0, rdy);
  endtask

  task automatic drain(string nm);
    repeat (8) idle(1);
    chk({nm, "_empty"}, expq.size(), 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_flags_q"}, flags_q, exp_fq);
    chk({nm, "_retired"}, retired_count, n_acc[15:0]);
    chk({nm, "_illegal"}, illegal_seen, exp_ill);
  endtask

  vec_t        tbl[8];
  logic [31:0] held;
  int          p0;
  int          tries;
  logic [3:0]  bp_ops[4];

  initial begin
    tbl[0] = '{4'd1,  32'hfffffff1, 32'h00000001, 4'd3, 1, 32'hfffffff2, 4'b0010};
    tbl[1] = '{4'd2,  32'h0000ffff, 32'h0000ffff, 4'd5, 1, 32'h00000000, 4'b0101};
    tbl[2] = '{4'd4,  32'h7e7e7e7e, 32'h5555aaaa, 4'd6, 0, 32'h54542a2a, 4'b0010};
    tbl[3] = '{4'd3,  32'hf0f0f0f0, 32'h0ff00ff0, 4'd7, 0, 32'hff00ff00, 4'b0010};
    tbl[4] = '{4'd8,  32'h12340000, 32'h00005678, 4'd8, 0, 32'h12345678, 4'b0010};
    tbl[5] = '{4'd15, 32'h00000005, 32'h00000006, 4'd9, 0, 32'h00000000, 4'b0100};
    tbl[6] = '{4'd1,  32'hffffffff, 32'h00000002, 4'd10, 1, 32'h00000001, 4'b1010};
    tbl[7] = '{4'd2,  32'h00000003, 32'h00000005, 4'd11, 1, 32'hfffffffe, 4'b1000};

    rst = 1'b1;
    in_valid = 0; in_opcode = 0; in_num_0 = 0; in_num_1 = 0;
    in_tag = 0; in_set_flags = 0; out_ready = 0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_num_0", alu_num_0, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags_q", flags_q, 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_illegal", illegal_seen, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed vectors, one at a time with latency checks
    for (int i = 0; i < 8; i++) begin
      cyc(1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].sf, 1);
      chk("vec_accept", last_acc, 1);
      chk("vec_alu_opcode", alu_opcode, legal(tbl[i].op) ? tbl[i].op : 4'd0);
      chk("vec_lat1_valid", out_valid, 0);
      idle(0);
      chk("vec_lat2_valid", out_valid, 1);
      chk("vec_data", out_data, tbl[i].d);
      chk("vec_tag", out_tag, tbl[i].tag);
      chk("vec_flags", out_flags, tbl[i].f);
      chk("vec_flags_q", flags_q, exp_fq);
      if (i == 2) chk("and_keeps_sub_flags", flags_q, 4'b0101);
      if (i >= 5) chk("illegal_sticky", illegal_seen, 1);
      idle(1);
    end
    drain("directed");

    // Backpressure: four ops with out_ready low
    bp_ops[0] = 4'd3; bp_ops[1] = 4'd8; bp_ops[2] = 4'd1; bp_ops[3] = 4'd2;
    p0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      cyc(1, bp_ops[i], 32'h100 + i, 32'h3 * i, 4'(i), 1, 0);
      chk("bp_accept", last_acc, 1);
    end
    held = out_data;
    for (int k = 0; k < 3; k++) begin
      cyc(1, bp_ops[3], 32'h77, 32'h7, 4'd3, 1, 0);
      chk("bp_stall", last_acc, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out_data, held);
    end
    tries = 0;
    do begin
      cyc(1, bp_ops[3], 32'h77, 32'h7, 4'd3, 1, 1);
      tries++;
    end while (!last_acc && tries < 6);
    chk("bp_4th_accept", last_acc, 1);
    drain("bp");
    chk("bp_retired4", n_acc - p0, 4);

    // Continuous stream: one result per cycle
    p0 = n_pops;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 4'd1, 32'(i * 1000), 32'(i), 4'(i), 0, 1);
      chk("stream_accept", last_acc, 1);
    end
    idle(1);
    idle(1);
    chk("stream_pops", n_pops - p0, 6);
    drain("stream");

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 7))
        0: op = 4'd0;
        1: op = 4'd1;
        2: op = 4'd2;
        3: op = 4'd3;
        4: op = 4'd4;
        5: op = 4'd8;
        default: op = 4'($urandom);
      endcase
      cyc($urandom_range(0, 3) != 0, op, $urandom, $urandom,
          4'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
    end
    drain("random");

    // Async reset with buffer full and S1 occupied
    for (int i = 0; i < 3; i++)
      cyc(1, 4'd1, 32'h50 + i, 32'h1, 4'(12 + i), 1, 0);
    chk("prerst_full", out_valid && !in_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_flags_q", flags_q, 0);
    chk("arst_retired", retired_count, 0);
    chk("arst_illegal", illegal_seen, 0);
    expq.delete();
    n_acc   = 0;
    exp_fq  = 4'd0;
    exp_ill = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drain("postrst");
    #1;
    chk("postrst_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Pipeline stage that sits directly upstream and downstream of the combinational alu. It accepts operations over a valid/ready handshake and registers the opcode and operands that drive the alu. It captures num_out and the four alu flags into a 2-entry result buffer presented to writeback over valid/ready. It also keeps an architectural flag register, an illegal-opcode sticky bit and a retired-op counter.

Parameters:
BUS_WIDTH, 32, operand/result width; must match the alu instance.
TAG_WIDTH, 4, width of the destination tag carried alongside each op.
COUNT_WIDTH, 16, width of the retired-op counter.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  upstream op valid.
in_ready  out  1  stage can accept op.
in_opcode  in  4  NUL=0000 ADD=0001 SUB=0010 XOR=0011 AND=0100 OR=1000.
in_num_0  in  BUS_WIDTH  operand 0.
in_num_1  in  BUS_WIDTH  operand 1.
in_tag  in  TAG_WIDTH  destination tag.
in_set_flags  in  1  op updates architectural flags on retire.
alu_opcode  out  4  registered opcode to alu.
alu_num_0  out  BUS_WIDTH  registered operand 0 to alu.
alu_num_1  out  BUS_WIDTH  registered operand 1 to alu.
alu_num_out  in  BUS_WIDTH  alu result.
alu_over, alu_zero, alu_greater, alu_equal  in  1 each  alu flags.
out_valid  out  1  result buffer non-empty.
out_ready  in  1  downstream accepts head entry.
out_data  out  BUS_WIDTH  head result.
out_tag  out  TAG_WIDTH  head tag.
out_flags  out  4  head flags {over,zero,greater,equal}.
flags_q  out  4  architectural flags {over,zero,greater,equal}.
illegal_seen  out  1  sticky: an illegal opcode was accepted.
retired_count  out  COUNT_WIDTH  ops pushed into result buffer.

Behaviour:
- Reset (async, rst=1): s1_valid=0; alu_opcode=NUL, alu_num_0/1=0; buffer count=0 (out_valid=0, out_data/out_tag/out_flags=0); flags_q=0; illegal_seen=0; retired_count=0. In-flight ops are discarded; after rst deasserts, in_ready=1 on the first edge.
- S1 (operand) register: s1_move = s1_valid && (count<2 || (out_valid && out_ready)). in_ready = !s1_valid || s1_move. On in_valid && in_ready, load opcode/operands/tag/set_flags and set s1_valid=1. Otherwise clear s1_valid when s1_move.
- Opcode check: any opcode outside the six legal codes is loaded as NUL. Operands are loaded unchanged. illegal_seen is set the same edge and stays set until reset.
- The alu is combinational on S1 outputs. On s1_move, push {alu_num_out, tag, 4 flags} into the buffer.
- Latency: op accepted at edge N is driven to the alu during cycle N+1 and pushed at edge N+1. out_valid is high in cycle N+1→N+2, i.e. 2 edges after acceptance when the buffer is empty. Throughput is 1 op/cycle when out_ready=1.
- Result buffer: 2-entry in-order FIFO with pointer wrap. Pop on out_valid && out_ready.
  - Full with a simultaneous pop and push is allowed; count stays 2.
  - Empty: no push and no pop.
  - Outputs show the head entry. They hold stable while out_valid && !out_ready.
- flags_q is loaded from alu flags on the push edge when the S1 set_flags bit is 1; otherwise it holds.
- retired_count increments on each push and wraps at 2^COUNT_WIDTH.
- Backpressure: with out_ready=0, at most 3 ops are held (2 in the buffer, 1 in S1). in_ready drops the cycle S1 is full and the buffer count is 2.

Test Plan:
- After rst, ADD 0xfffffff1+0x00000001 tag 3, set_flags=1 → out_valid 2 edges after acceptance; out_data=0xfffffff2, out_tag=3; flags_q=out_flags, zero=0.
- SUB 0x0000ffff−0x0000ffff set_flags=1, then AND 0x7e7e7e7e&0x5555aaaa set_flags=0 → outputs 0x00000000 (zero=1, equal=1) then 0x54542a2a; flags_q keeps the SUB flags.
- out_ready=0, issue XOR, OR, ADD, SUB back-to-back → in_ready=0 after 3 accepted. The 4th op stalls and out_data holds. Release out_ready → results in order with no loss or duplication. retired_count=4.
- Illegal opcode 4'b1111, operands 5/6 → alu_opcode=NUL, illegal_seen=1 and sticky, result pushed with its tag.
- Continuous stream of 6 ADDs with out_ready=1 → one result per cycle, in_ready stays 1.
- Assert rst with 2 entries buffered and S1 full → out_valid=0, flags_q=0 and retired_count=0 immediately (async). The pre-reset ops never appear.
